// File: rtl/chrono_lap_logger.sv
// Chronometer: up/down tick counter with lap logging to an external memory
// and lap recall over a read handshake.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start_d/stop_d/lap_d/restart_d  one-hot commands (other mixes ignored)
//   down_mode, preset             countdown mode and start value
//   recall_req, recall_idx        lap read-back request
//   value, running, expired       count state
//   lap_count                     stored laps, saturating at LAP_DEPTH
//   wr_en/wr_addr/wr_data         lap memory write port
//   rd_en/rd_addr/rd_data/rd_done lap memory read handshake
//   recall_valid/err/data         recall result
module chrono_lap_logger #(
  parameter int TICK_DIV  = 5000000,
  parameter int CNT_W     = 16,
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 16,
  parameter int LAP_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_d,
  input  logic                 stop_d,
  input  logic                 lap_d,
  input  logic                 restart_d,
  input  logic                 down_mode,
  input  logic [CNT_W-1:0]     preset,
  input  logic                 recall_req,
  input  logic [ADDR_SIZE-1:0] recall_idx,
  output logic [CNT_W-1:0]     value,
  output logic                 running,
  output logic                 expired,
  output logic [ADDR_SIZE:0]   lap_count,
  output logic                 wr_en,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [DATA_SIZE-1:0] wr_data,
  output logic                 rd_en,
  output logic [ADDR_SIZE-1:0] rd_addr,
  input  logic [DATA_SIZE-1:0] rd_data,
  input  logic                 rd_done,
  output logic                 recall_valid,
  output logic                 recall_err,
  output logic [DATA_SIZE-1:0] recall_data
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST =
    PW'(TICK_DIV - 1);
  localparam logic [ADDR_SIZE-1:0] A_LAST =
    ADDR_SIZE'(LAP_DEPTH - 1);
  localparam logic [ADDR_SIZE:0] C_FULL =
    (ADDR_SIZE + 1)'(LAP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_RECALL
  } state_t;

  state_t state;
  state_t ret_state;

  logic                 down;
  logic [PW-1:0]        presc;
  logic [ADDR_SIZE-1:0] ptr;

  logic cmd_ok;
  logic go;
  logic halt;
  logic lap;
  logic clr;
  logic tick;
  logic lap_ok;
  logic recall_bad;

  logic [CNT_W-1:0]     val_dn;
  logic [ADDR_SIZE-1:0] ptr_nxt;
  logic [ADDR_SIZE:0]   cnt_nxt;

  assign cmd_ok = $onehot({start_d, stop_d, lap_d, restart_d});
  assign go     = cmd_ok & start_d;
  assign halt   = cmd_ok & stop_d;
  assign lap    = cmd_ok & lap_d;
  assign clr    = cmd_ok & restart_d;

  assign tick   = (presc == P_LAST);
  assign lap_ok = lap &&
    (state == S_RUN || state == S_PAUSE);

  assign val_dn  = value - CNT_W'(1);
  assign ptr_nxt = (ptr == A_LAST) ? '0
                 : ptr + ADDR_SIZE'(1);
  assign cnt_nxt = (lap_count == C_FULL) ? lap_count
                 : lap_count + (ADDR_SIZE + 1)'(1);

  assign recall_bad = ({1'b0, recall_idx} >= lap_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ret_state    <= S_IDLE;
      down         <= 1'b0;
      presc        <= '0;
      ptr          <= '0;
      value        <= '0;
      running      <= 1'b0;
      expired      <= 1'b0;
      lap_count    <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      recall_valid <= 1'b0;
      recall_err   <= 1'b0;
      recall_data  <= '0;
    end else begin
      wr_en        <= 1'b0;
      recall_valid <= 1'b0;
      recall_err   <= 1'b0;
      if (clr) begin
        state     <= S_IDLE;
        running   <= 1'b0;
        value     <= '0;
        expired   <= 1'b0;
        ptr       <= '0;
        lap_count <= '0;
        presc     <= '0;
        rd_en     <= 1'b0;
      end else begin
        // Logged value is the register before any tick on this edge.
        if (lap_ok) begin
          wr_en     <= 1'b1;
          wr_addr   <= ptr;
          wr_data   <= DATA_SIZE'(value);
          ptr       <= ptr_nxt;
          lap_count <= cnt_nxt;
        end
        unique case (state)
          S_IDLE: begin
            if (go) begin
              presc <= '0;
              down  <= down_mode;
              value <= down_mode ? preset : '0;
              if (down_mode && preset == '0) begin
                expired <= 1'b1;
                state   <= S_PAUSE;
              end else begin
                running <= 1'b1;
                state   <= S_RUN;
              end
            end else if (recall_req) begin
              if (recall_bad) begin
                recall_err <= 1'b1;
              end else begin
                rd_addr   <= recall_idx;
                rd_en     <= 1'b1;
                ret_state <= S_IDLE;
                state     <= S_RECALL;
              end
            end
          end
          S_RUN: begin
            // Stop freezes the prescaler on the edge it is taken.
            if (halt) begin
              running <= 1'b0;
              state   <= S_PAUSE;
            end else begin
              presc <= tick ? '0 : presc + PW'(1);
              if (tick) begin
                if (down) begin
                  value <= val_dn;
                  if (val_dn == '0) begin
                    expired <= 1'b1;
                    running <= 1'b0;
                    state   <= S_PAUSE;
                  end
                end else begin
                  value <= value + CNT_W'(1);
                end
              end
            end
          end
          S_PAUSE: begin
            if (go && !expired) begin
              running <= 1'b1;
              state   <= S_RUN;
            end else if (recall_req && !lap) begin
              if (recall_bad) begin
                recall_err <= 1'b1;
              end else begin
                rd_addr   <= recall_idx;
                rd_en     <= 1'b1;
                ret_state <= S_PAUSE;
                state     <= S_RECALL;
              end
            end
          end
          S_RECALL: begin
            if (rd_done) begin
              recall_data  <= rd_data;
              recall_valid <= 1'b1;
              rd_en        <= 1'b0;
              state        <= ret_state;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chrono_lap_logger.sv
// Directed bench for chrono_lap_logger.
// Small tick divider and lap depth; memory is a local array model.
module tb_chrono_lap_logger;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_d = 0, stop_d = 0, lap_d = 0, restart_d = 0;
  logic        down_mode = 0;
  logic [15:0] preset = 0;
  logic        recall_req = 0;
  logic [3:0]  recall_idx = 0;
  logic [15:0] value;
  logic        running, expired;
  logic [4:0]  lap_count;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data = 0;
  logic        rd_done = 0;
  logic        recall_valid, recall_err;
  logic [15:0] recall_data;

  int checks = 0;
  int failures = 0;
  logic [15:0] mem [0:15];

  chrono_lap_logger #(
    .TICK_DIV(4), .CNT_W(16), .ADDR_SIZE(4),
    .DATA_SIZE(16), .LAP_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .start_d(start_d), .stop_d(stop_d),
    .lap_d(lap_d), .restart_d(restart_d),
    .down_mode(down_mode), .preset(preset),
    .recall_req(recall_req), .recall_idx(recall_idx),
    .value(value), .running(running), .expired(expired),
    .lap_count(lap_count),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_done(rd_done),
    .recall_valid(recall_valid), .recall_err(recall_err),
    .recall_data(recall_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic p_start;
    start_d = 1; cyc(); start_d = 0;
  endtask

  task automatic p_stop;
    stop_d = 1; cyc(); stop_d = 0;
  endtask

  task automatic p_restart;
    restart_d = 1; cyc(); restart_d = 0;
  endtask

  task automatic lap_at(input logic [15:0] v);
    int n;
    n = 0;
    while (value !== v && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (value !== v) begin
      failures++;
      $display("FAIL lap_wait act=%0d exp=%0d", value, v);
    end
    lap_d = 1; cyc(); lap_d = 0;
  endtask

  task automatic test_reset;
    rst = 1; idle(2); rst = 0;
    checks++;
    if ({value, running, expired, lap_count, wr_en, rd_en,
         recall_valid, recall_err, recall_data} !== '0) begin
      failures++;
      $display("FAIL reset_outs value=%0d run=%b exp=%b cnt=%0d",
               value, running, expired, lap_count);
    end
  endtask

  task automatic test_illegal;
    start_d = 1; stop_d = 1; cyc();
    start_d = 0; stop_d = 0;
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL illegal_cmd running act=%b exp=0", running);
    end
  endtask

  task automatic test_up_pause;
    down_mode = 0;
    p_start();
    checks++;
    if (running !== 1'b1 || value !== 16'd0) begin
      failures++;
      $display("FAIL up_start run=%b value=%0d exp 1/0",
               running, value);
    end
    idle(12);
    checks++;
    if (value !== 16'd3) begin
      failures++;
      $display("FAIL up_12cyc act=%0d exp=3", value);
    end
    idle(2);
    p_stop();
    idle(10);
    checks++;
    if (value !== 16'd3 || running !== 1'b0) begin
      failures++;
      $display("FAIL pause_hold value=%0d run=%b exp 3/0",
               value, running);
    end
    p_start();
    cyc();
    checks++;
    if (value !== 16'd3 || running !== 1'b1) begin
      failures++;
      $display("FAIL resume_early value=%0d run=%b exp 3/1",
               value, running);
    end
    cyc();
    checks++;
    if (value !== 16'd4) begin
      failures++;
      $display("FAIL resume_tick act=%0d exp=4", value);
    end
    p_restart();
    checks++;
    if (value !== 16'd0 || running !== 1'b0) begin
      failures++;
      $display("FAIL restart_clr value=%0d run=%b exp 0/0",
               value, running);
    end
  endtask

  task automatic test_down;
    down_mode = 1; preset = 16'd2;
    p_start();
    checks++;
    if (value !== 16'd2) begin
      failures++;
      $display("FAIL down_load act=%0d exp=2", value);
    end
    idle(3);
    checks++;
    if (value !== 16'd2) begin
      failures++;
      $display("FAIL down_hold act=%0d exp=2", value);
    end
    cyc();
    checks++;
    if (value !== 16'd1) begin
      failures++;
      $display("FAIL down_tick1 act=%0d exp=1", value);
    end
    idle(4);
    checks++;
    if (value !== 16'd0 || expired !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL down_expire value=%0d exp=%b run=%b want 0/1/0",
               value, expired, running);
    end
    p_start();
    idle(5);
    checks++;
    if (running !== 1'b0 || expired !== 1'b1) begin
      failures++;
      $display("FAIL expired_start run=%b exp=%b want 0/1",
               running, expired);
    end
    p_restart();
    checks++;
    if (expired !== 1'b0) begin
      failures++;
      $display("FAIL restart_expired act=%b exp=0", expired);
    end
    preset = 16'd0;
    p_start();
    checks++;
    if (expired !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL preset0 exp=%b run=%b want 1/0",
               expired, running);
    end
    p_restart();
    down_mode = 0;
  endtask

  task automatic test_laps;
    p_start();
    lap_at(16'd1);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 16'd1) begin
      failures++;
      $display("FAIL lap0 en=%b addr=%0d data=%0d want 1/0/1",
               wr_en, wr_addr, wr_data);
    end
    cyc();
    checks++;
    if (wr_en !== 1'b0) begin
      failures++;
      $display("FAIL lap_pulse act=%b exp=0", wr_en);
    end
    lap_at(16'd4);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd1 || wr_data !== 16'd4) begin
      failures++;
      $display("FAIL lap1 en=%b addr=%0d data=%0d want 1/1/4",
               wr_en, wr_addr, wr_data);
    end
    lap_at(16'd7);
    checks++;
    if (wr_addr !== 4'd2 || wr_data !== 16'd7 || lap_count !== 5'd3) begin
      failures++;
      $display("FAIL lap2 addr=%0d data=%0d cnt=%0d want 2/7/3",
               wr_addr, wr_data, lap_count);
    end
    p_stop();
  endtask

  task automatic test_recall;
    int hi;
    recall_idx = 4'd1; recall_req = 1; cyc(); recall_req = 0;
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 4'd1) begin
      failures++;
      $display("FAIL recall_req en=%b addr=%0d want 1/1",
               rd_en, rd_addr);
    end
    hi = 1;
    cyc(); if (rd_en === 1'b1) hi++;
    cyc(); if (rd_en === 1'b1) hi++;
    rd_done = 1; rd_data = mem[rd_addr]; cyc(); rd_done = 0;
    checks++;
    if (hi != 3 || rd_en !== 1'b0) begin
      failures++;
      $display("FAIL rd_en_len hi=%0d en=%b want 3/0", hi, rd_en);
    end
    checks++;
    if (recall_valid !== 1'b1 || recall_data !== 16'd4) begin
      failures++;
      $display("FAIL recall_data v=%b data=%0d want 1/4",
               recall_valid, recall_data);
    end
    cyc();
    checks++;
    if (recall_valid !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL recall_after v=%b run=%b want 0/0",
               recall_valid, running);
    end
    recall_idx = 4'd5; recall_req = 1; cyc(); recall_req = 0;
    checks++;
    if (recall_err !== 1'b1 || rd_en !== 1'b0) begin
      failures++;
      $display("FAIL recall_err5 err=%b en=%b want 1/0",
               recall_err, rd_en);
    end
    cyc();
    checks++;
    if (recall_err !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse act=%b exp=0", recall_err);
    end
    recall_idx = 4'd3; recall_req = 1; cyc(); recall_req = 0;
    checks++;
    if (recall_err !== 1'b1 || rd_en !== 1'b0) begin
      failures++;
      $display("FAIL recall_err3 err=%b en=%b want 1/0",
               recall_err, rd_en);
    end
    recall_idx = 4'd2; recall_req = 1; cyc(); recall_req = 0;
    rd_done = 1; rd_data = mem[rd_addr]; cyc(); rd_done = 0;
    checks++;
    if (recall_valid !== 1'b1 || recall_data !== 16'd7) begin
      failures++;
      $display("FAIL recall_last v=%b data=%0d want 1/7",
               recall_valid, recall_data);
    end
  endtask

  task automatic test_saturate;
    p_start();
    checks++;
    if (running !== 1'b1 || value !== 16'd7) begin
      failures++;
      $display("FAIL back_to_pause run=%b value=%0d want 1/7",
               running, value);
    end
    lap_at(16'd8);
    checks++;
    if (wr_addr !== 4'd3 || lap_count !== 5'd4) begin
      failures++;
      $display("FAIL lap3 addr=%0d cnt=%0d want 3/4",
               wr_addr, lap_count);
    end
    lap_at(16'd9);
    checks++;
    if (wr_addr !== 4'd0 || lap_count !== 5'd4) begin
      failures++;
      $display("FAIL lap4 addr=%0d cnt=%0d want 0/4",
               wr_addr, lap_count);
    end
    lap_at(16'd10);
    checks++;
    if (wr_addr !== 4'd1 || wr_data !== 16'd10 || lap_count !== 5'd4) begin
      failures++;
      $display("FAIL lap5 addr=%0d data=%0d cnt=%0d want 1/10/4",
               wr_addr, wr_data, lap_count);
    end
    p_stop();
  endtask

  task automatic test_restart_recall;
    recall_idx = 4'd0; recall_req = 1; cyc(); recall_req = 0;
    checks++;
    if (rd_en !== 1'b1) begin
      failures++;
      $display("FAIL rr_rd_en act=%b exp=1", rd_en);
    end
    p_restart();
    checks++;
    if (rd_en !== 1'b0 || value !== 16'd0 || lap_count !== 5'd0) begin
      failures++;
      $display("FAIL rr_abort en=%b value=%0d cnt=%0d want 0/0/0",
               rd_en, value, lap_count);
    end
    rd_done = 1; rd_data = 16'hBEEF; cyc(); rd_done = 0;
    checks++;
    if (recall_valid !== 1'b0) begin
      failures++;
      $display("FAIL late_rd_done v=%b exp=0", recall_valid);
    end
  endtask

  task automatic test_rst_wr;
    p_start();
    lap_d = 1; cyc(); lap_d = 0;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd0) begin
      failures++;
      $display("FAIL pre_rst_lap en=%b addr=%0d want 1/0",
               wr_en, wr_addr);
    end
    rst = 1; cyc(); rst = 0;
    checks++;
    if ({value, running, expired, lap_count, wr_en, wr_addr,
         wr_data, rd_en, recall_valid, recall_data} !== '0) begin
      failures++;
      $display("FAIL rst_mid en=%b value=%0d cnt=%0d run=%b",
               wr_en, value, lap_count, running);
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_up_pause();
    test_down();
    test_laps();
    test_recall();
    test_saturate();
    test_restart_recall();
    test_rst_wr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chrono_lap_logger.md
Name: chrono_lap_logger

Overview:
- Parametrised next-generation chronometer controller.
- Counts prescaled ticks up (stopwatch) or down from a preset (timer), and logs lap values to an external single-port-style lap memory through a write port.
- Recalls any stored lap through a read handshake.
- Sits between the debounced button front end and the display/memory blocks.

Parameters:
TICK_DIV  5000000  clk cycles per count tick (>=2)
CNT_W  16  width of displayed count value
ADDR_SIZE  10  lap memory address width
DATA_SIZE  16  lap memory data width
LAP_DEPTH  1024  number of lap slots used (<= 2**ADDR_SIZE)

Ports:
clk  in  1  system clock
rst  in  1  reset
start_d  in  1  start/resume command (debounced level, one cycle pulse)
stop_d  in  1  pause command
lap_d  in  1  log current value command
restart_d  in  1  clear/return-to-idle command
down_mode  in  1  1 = count down from preset, sampled on start from IDLE
preset  in  CNT_W  countdown start value, sampled on start from IDLE
recall_req  in  1  request read-back of lap recall_idx
recall_idx  in  ADDR_SIZE  lap slot to recall
value  out  CNT_W  current count
running  out  1  high in RUN
expired  out  1  countdown reached 0; sticky until restart
lap_count  out  ADDR_SIZE+1  laps stored, saturates at LAP_DEPTH
wr_en  out  1  lap memory write strobe
wr_addr  out  ADDR_SIZE  lap memory write address
wr_data  out  DATA_SIZE  lap memory write data
rd_en  out  1  lap memory read request
rd_addr  out  ADDR_SIZE  lap memory read address
rd_data  in  DATA_SIZE  lap memory read data, valid with rd_done
rd_done  in  1  read complete strobe
recall_valid  out  1  one-cycle pulse, recall_data valid
recall_err  out  1  one-cycle pulse, recall_idx >= lap_count
recall_data  out  DATA_SIZE  last recalled lap value

Behaviour:
- Interface: one clock clk; rst is synchronous and active-high. All outputs are registered. At reset every output is 0, the state is IDLE, and the lap pointer and prescaler are 0.
- A command is legal only when exactly one of start_d/stop_d/lap_d/restart_d is high. Any other combination is ignored.
- Effect latency: the command is sampled at edge n; outputs reflect it after edge n.
- States: IDLE, RUN, PAUSE, RECALL.
- IDLE:
  - start: value <= down_mode ? preset : 0; latch mode; prescaler <= 0; go to RUN.
  - Down mode with preset == 0: expired <= 1, go to PAUSE.
- RUN:
  - The prescaler counts each cycle. When it equals TICK_DIV-1 it wraps to 0 and a tick occurs.
  - Up-mode tick: value+1, wrapping from 2**CNT_W-1 to 0.
  - Down-mode tick: value-1. When the result is 0, set expired and go to PAUSE.
  - stop: go to PAUSE; the prescaler is frozen, not cleared.
- PAUSE:
  - start resumes RUN with the prescaler intact; it is ignored when expired=1.
- lap in RUN or PAUSE:
  - Write strobe: wr_en=1 for exactly one cycle.
  - Write address and data: wr_addr=lap pointer; wr_data=value zero-extended or truncated to DATA_SIZE.
  - Pointer update: pointer+1 mod LAP_DEPTH; lap_count+1, saturating at LAP_DEPTH (oldest slot overwritten).
  - Lap coincident with a tick logs the pre-tick value.
- recall_req in IDLE or PAUSE (ignored in RUN):
  - recall_idx >= lap_count: recall_err pulse; no state change.
  - Otherwise: rd_addr <= recall_idx, rd_en <= 1, go to RECALL.
- RECALL:
  - rd_en is held high until rd_done.
  - On rd_done: recall_data <= rd_data, recall_valid pulse, rd_en <= 0, return to the originating state (IDLE or PAUSE).
  - start/stop/lap are ignored. restart aborts to IDLE with rd_en <= 0; a later rd_done is ignored.
- restart in any state:
  - Go to IDLE; value <= 0; expired <= 0.
  - Lap pointer and lap_count <= 0; prescaler <= 0.
  - Memory contents are untouched.
- rst mid-operation overrides everything, including a pending wr_en or rd_en, which drop on the next cycle.

Test Plan:
- TICK_DIV=4, up mode; start, wait 12 cycles -> value=3; stop for 10 cycles -> value holds 3; start -> next tick after the remaining prescaler count.
- Down mode, preset=2, TICK_DIV=4 -> value 2,1,0 at 4-cycle spacing; expired=1, running=0; a start in PAUSE is ignored.
- Run 3 laps at values 1,4,7 -> wr_en pulses with wr_addr 0,1,2, wr_data 1,4,7; lap_count=3.
- LAP_DEPTH=4, 6 laps -> wr_addr sequence 0,1,2,3,0,1; lap_count saturates at 4.
- PAUSE, recall idx 1, memory model returns 4 after 3 cycles -> rd_en high 3 cycles, recall_valid pulse, recall_data=4, back to PAUSE. Recall idx 5 with lap_count=3 -> recall_err pulse only.
- Robustness: start+stop together is ignored. Restart during RECALL -> IDLE, value=0, a late rd_done gives no recall_valid. rst asserted during a wr_en cycle -> all outputs 0 next cycle.
